fmc_cmd_bridge: RTL and testbench

// - FMC slave: accepts STM32F FMC async 16-bit transactions (two phases per 32-bit access, NE1 held low

---
 rtl/fmc_cmd_bridge_if.sv | 40 ++++
 rtl/fmc_cmd_bridge.sv | 273 +++++++++++++++++++++++++++
 tb/tb_fmc_cmd_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmc_cmd_bridge_if.sv
// rtl/fmc_cmd_bridge_if.sv - FMC async bus and command bus bundle for fmc_cmd_bridge
interface fmc_cmd_bridge_if;
   logic [24:0] i_fmc_a;
   logic        i_fmc_ne1;
   logic        i_fmc_noe;
   logic        i_fmc_nwe;
   wire  [15:0] io_fmc_d;
   logic [15:0] fmc_d_out;
   logic        fmc_d_oe;
   logic [15:0] host_d_out;
   logic        host_d_oe;
   logic        o_fmc_nwait;
   logic        o_cmd_vld;
   logic        o_cmd_rd_wr_n;
   logic [25:0] o_cmd_addr;
   logic [31:0] o_cmd_wdata;
   logic        i_cmd_ack;
   logic [31:0] i_cmd_rdata;
   logic        o_err_timeout;

   // Shared data pins: bridge drives on reads, host drives on writes, otherwise released.
   assign io_fmc_d = fmc_d_oe  ? fmc_d_out  :
                     host_d_oe ? host_d_out : 16'hzzzz;

   modport slave (
      input  i_fmc_a, i_fmc_ne1, i_fmc_noe, i_fmc_nwe, io_fmc_d,
      output fmc_d_out, fmc_d_oe, o_fmc_nwait,
      output o_cmd_vld, o_cmd_rd_wr_n, o_cmd_addr, o_cmd_wdata,
      input  i_cmd_ack, i_cmd_rdata,
      output o_err_timeout
   );

   modport master (
      output i_fmc_a, i_fmc_ne1, i_fmc_noe, i_fmc_nwe, host_d_out, host_d_oe,
      input  io_fmc_d, fmc_d_out, fmc_d_oe, o_fmc_nwait,
      input  o_cmd_vld, o_cmd_rd_wr_n, o_cmd_addr, o_cmd_wdata,
      output i_cmd_ack, i_cmd_rdata,
      input  o_err_timeout
   );
endinterface

// File: rtl/fmc_cmd_bridge.sv
// rtl/fmc_cmd_bridge.sv - STM32 FMC async 16-bit slave turning two-phase accesses into 32-bit commands
// Optional macro FMC_BRIDGE_ADDR_CHECK_EN: phase-2 address must equal phase-1 address + 1.
module fmc_cmd_bridge #(
   parameter int unsigned P_CMD_ACK_TIMEOUT_CLKS = 16,
   parameter logic [31:0] P_TIMEOUT_RDATA        = 32'hDEAD_BEEF,
   parameter int unsigned P_SYNC_STAGES          = 2,
   parameter int unsigned P_NWAIT_HOLD_CLKS      = 2
) (
   input logic             i_sys_clk,
   input logic             i_rst_n,
   fmc_cmd_bridge_if.slave bus
);
   localparam int SW = 44;
   localparam int CW = $clog2(P_CMD_ACK_TIMEOUT_CLKS + 1);
   localparam int HW = $clog2(P_NWAIT_HOLD_CLKS + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(P_CMD_ACK_TIMEOUT_CLKS - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(P_CMD_ACK_TIMEOUT_CLKS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(P_NWAIT_HOLD_CLKS - 1);
   localparam logic [SW-1:0] SYNC_RST  = {3'b111, 41'd0};

   typedef enum logic [2:0] {S_IDLE, S_W1, S_W2, S_R1, S_R2, S_CMD, S_NEND} state_t;

   // Reset asserts immediately but releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= rst_sync_d;
   end

   logic [SW-1:0] sync_q [P_SYNC_STAGES];
   logic [SW-1:0] sync_d [P_SYNC_STAGES];

   always_comb begin
      sync_d[0] = {bus.i_fmc_ne1, bus.i_fmc_noe, bus.i_fmc_nwe, bus.i_fmc_a, bus.io_fmc_d};
      for (int i = 1; i < P_SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   always_ff @(posedge i_sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < P_SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      end else begin
         for (int i = 0; i < P_SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      end
   end

   logic        ne1_s, noe_s, nwe_s;
   logic [24:0] a_s;
   logic [15:0] d_s;

   assign ne1_s = sync_q[P_SYNC_STAGES-1][43];
   assign noe_s = sync_q[P_SYNC_STAGES-1][42];
   assign nwe_s = sync_q[P_SYNC_STAGES-1][41];
   assign a_s   = sync_q[P_SYNC_STAGES-1][40:16];
   assign d_s   = sync_q[P_SYNC_STAGES-1][15:0];

   state_t        state_q, state_d;
   logic          noe_prev_q, noe_prev_d;
   logic          nwe_prev_q, nwe_prev_d;
   logic          nwait_q, nwait_d;
   logic          cmd_vld_q, cmd_vld_d;
   logic          rd_wr_n_q, rd_wr_n_d;
   logic [25:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          p1_done_q, p1_done_d;
   logic          done_q, done_d;
   logic          drive_q, drive_d;
   logic [15:0]   d_out_q, d_out_d;
   logic          d_oe_q, d_oe_d;

   logic noe_fall, noe_rise, nwe_fall, nwe_rise, addr_ok;

   assign noe_fall = !ne1_s &&  noe_prev_q && !noe_s;
   assign noe_rise = !ne1_s && !noe_prev_q &&  noe_s;
   assign nwe_fall = !ne1_s &&  nwe_prev_q && !nwe_s;
   assign nwe_rise = !ne1_s && !nwe_prev_q &&  nwe_s;

`ifdef FMC_BRIDGE_ADDR_CHECK_EN
   assign addr_ok = (a_s == addr_q[25:1] + 25'd1);
`else
   assign addr_ok = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      noe_prev_d = noe_s;
      nwe_prev_d = nwe_s;
      nwait_d    = nwait_q;
      cmd_vld_d  = 1'b0;
      rd_wr_n_d  = rd_wr_n_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      p1_done_d  = p1_done_q;
      done_d     = done_q;
      drive_d    = drive_q;
      d_out_d    = d_out_q;

      case (state_q)
         S_IDLE: begin
            p1_done_d = 1'b0;
            done_d    = 1'b0;
            drive_d   = 1'b0;
            nwait_d   = 1'b1;
            if (nwe_fall) begin
               state_d = S_W1;
            end else if (noe_fall) begin
               state_d = S_R1;
               nwait_d = 1'b0;
            end
         end
         S_W1: begin
            if (ne1_s) begin
               state_d = S_IDLE;
            end else if (nwe_rise && !p1_done_q) begin
               addr_d        = {a_s, 1'b0};
               wdata_d[15:0] = d_s;
               p1_done_d     = 1'b1;
            end else if (nwe_fall && p1_done_q) begin
               state_d = S_W2;
               nwait_d = 1'b0;
            end
         end
         S_W2: begin
            if (ne1_s) begin
               state_d = S_IDLE;
               nwait_d = 1'b1;
            end else if (addr_ok) begin
               wdata_d[31:16] = d_s;
               cmd_vld_d      = 1'b1;
               rd_wr_n_d      = 1'b0;
               cnt_d          = '0;
               state_d        = S_CMD;
            end else begin
               nwait_d = 1'b1;
               state_d = S_NEND;
            end
         end
         S_R1: begin
            if (ne1_s) begin
               state_d = S_IDLE;
               nwait_d = 1'b1;
            end else begin
               addr_d    = {a_s, 1'b0};
               cmd_vld_d = 1'b1;
               rd_wr_n_d = 1'b1;
               cnt_d     = '0;
               state_d   = S_CMD;
            end
         end
         S_CMD: begin
            if (!done_q) begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
               // An ack arriving on the limit cycle still counts as a normal completion.
               if (bus.i_cmd_ack || cnt_q == CNT_LAST) begin
                  done_d = 1'b1;
                  err_d  = !bus.i_cmd_ack;
                  if (rd_wr_n_q) begin
                     rdata_d = bus.i_cmd_ack ? bus.i_cmd_rdata : P_TIMEOUT_RDATA;
                     if (ne1_s) begin
                        state_d = S_IDLE;
                        nwait_d = 1'b1;
                     end else begin
                        drive_d = 1'b1;
                        d_out_d = rdata_d[15:0];
                        hold_d  = '0;
                     end
                  end else begin
                     nwait_d = 1'b1;
                     state_d = ne1_s ? S_IDLE : S_NEND;
                  end
               end
            end else if (ne1_s) begin
               state_d = S_IDLE;
               nwait_d = 1'b1;
               drive_d = 1'b0;
            end else if (noe_rise) begin
               state_d = S_R2;
               nwait_d = 1'b1;
               drive_d = 1'b0;
            end else if (hold_q == HOLD_LAST) begin
               nwait_d = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_R2: begin
            if (ne1_s) begin
               state_d = S_IDLE;
            end else if (noe_fall) begin
               drive_d = 1'b1;
               d_out_d = addr_ok ? rdata_q[31:16] : 16'h0000;
               state_d = S_NEND;
            end
         end
         S_NEND: begin
            if (ne1_s) begin
               state_d = S_IDLE;
               drive_d = 1'b0;
               nwait_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            nwait_d = 1'b1;
            drive_d = 1'b0;
         end
      endcase

      d_oe_d = drive_d && !ne1_s && !noe_s;
   end

   always_ff @(posedge i_sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         noe_prev_q <= 1'b1;
         nwe_prev_q <= 1'b1;
         nwait_q    <= 1'b1;
         cmd_vld_q  <= 1'b0;
         rd_wr_n_q  <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         hold_q     <= '0;
         p1_done_q  <= 1'b0;
         done_q     <= 1'b0;
         drive_q    <= 1'b0;
         d_out_q    <= '0;
         d_oe_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         noe_prev_q <= noe_prev_d;
         nwe_prev_q <= nwe_prev_d;
         nwait_q    <= nwait_d;
         cmd_vld_q  <= cmd_vld_d;
         rd_wr_n_q  <= rd_wr_n_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         p1_done_q  <= p1_done_d;
         done_q     <= done_d;
         drive_q    <= drive_d;
         d_out_q    <= d_out_d;
         d_oe_q     <= d_oe_d;
      end
   end

   assign bus.o_fmc_nwait   = nwait_q;
   assign bus.o_cmd_vld     = cmd_vld_q;
   assign bus.o_cmd_rd_wr_n = rd_wr_n_q;
   assign bus.o_cmd_addr    = addr_q;
   assign bus.o_cmd_wdata   = wdata_q;
   assign bus.o_err_timeout = err_q;
   assign bus.fmc_d_out     = d_out_q;
   assign bus.fmc_d_oe      = d_oe_q;
endmodule

// File: tb/tb_fmc_cmd_bridge.sv
// tb/tb_fmc_cmd_bridge.sv - scoreboard bench for fmc_cmd_bridge
module tb_fmc_cmd_bridge;
   logic clk;
   logic rst_n;

   fmc_cmd_bridge_if bus();

   fmc_cmd_bridge dut (
      .i_sys_clk (clk),
      .i_rst_n   (rst_n),
      .bus       (bus)
   );

   typedef struct {
      logic        rd;
      logic [25:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   cmd_t        exp_cmd [$];
   logic [31:0] exp_rd  [$];
   logic [31:0] obs_rd  [$];
   int          exp_err;
   int          n_cmp;
   int          n_bad;
   int          cyc;
   int          vld_cyc;
   int          ack_delay;
   logic [31:0] ack_rdata;
   int          late_req;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_cmd(input logic rd, input logic [25:0] addr, input logic [31:0] wdata);
      cmd_t c;
      c.rd    = rd;
      c.addr  = addr;
      c.wdata = wdata;
      exp_cmd.push_back(c);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   // Downstream MIB stand-in: acks ack_delay clocks after cmd_vld, or on request.
   initial begin : model
      int late_done;
      late_done = 0;
      bus.i_cmd_ack   = 1'b0;
      bus.i_cmd_rdata = '0;
      forever begin
         @(negedge clk);
         if (late_req != late_done) begin
            late_done       = late_req;
            bus.i_cmd_ack   = 1'b1;
            bus.i_cmd_rdata = ack_rdata;
            @(negedge clk);
            bus.i_cmd_ack   = 1'b0;
            bus.i_cmd_rdata = '0;
         end else if (bus.o_cmd_vld && ack_delay > 0) begin
            repeat (ack_delay - 1) @(negedge clk);
            bus.i_cmd_ack   = 1'b1;
            bus.i_cmd_rdata = ack_rdata;
            @(negedge clk);
            bus.i_cmd_ack   = 1'b0;
            bus.i_cmd_rdata = '0;
         end
      end
   end

   initial begin : monitor
      cmd_t        c;
      logic [31:0] o;
      logic [31:0] e;
      vld_cyc = 0;
      forever begin
         @(negedge clk);
         if (bus.o_cmd_vld) begin
            vld_cyc = cyc;
            if (exp_cmd.size() == 0) begin
               check("unexpected_cmd_vld", 1, 0);
            end else begin
               c = exp_cmd.pop_front();
               check("cmd_rd_wr_n", bus.o_cmd_rd_wr_n, c.rd);
               check("cmd_addr", bus.o_cmd_addr, c.addr);
               if (!c.rd) check("cmd_wdata", bus.o_cmd_wdata, c.wdata);
            end
         end
         if (bus.o_err_timeout) begin
            if (exp_err == 0) begin
               check("unexpected_err_timeout", 1, 0);
            end else begin
               exp_err = exp_err - 1;
               check("timeout_latency", cyc - vld_cyc, 16);
            end
         end
         if (obs_rd.size() > 0) begin
            o = obs_rd.pop_front();
            if (exp_rd.size() == 0) begin
               check("unexpected_fmc_read", 1, 0);
            end else begin
               e = exp_rd.pop_front();
               check("fmc_rdata", o, e);
            end
         end
      end
   end

   task automatic fmc_write(input logic [25:0] baddr, input logic [31:0] data,
                            input logic [24:0] a2, input bit exp_wait);
      int n;
      bit seen_low;
      bus.i_fmc_ne1  = 1'b0;
      bus.i_fmc_a    = baddr[25:1];
      bus.host_d_out = data[15:0];
      bus.host_d_oe  = 1'b1;
      repeat (2) @(negedge clk);
      bus.i_fmc_nwe = 1'b0;
      repeat (4) @(negedge clk);
      check("nwait_high_wr_phase1", bus.o_fmc_nwait, 1);
      bus.i_fmc_nwe = 1'b1;
      repeat (4) @(negedge clk);
      bus.i_fmc_a    = a2;
      bus.host_d_out = data[31:16];
      repeat (2) @(negedge clk);
      bus.i_fmc_nwe = 1'b0;
      if (exp_wait) begin
         n = 0;
         while (bus.o_fmc_nwait && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("nwait_low_wr_phase2", bus.o_fmc_nwait, 0);
         n = 0;
         while (!bus.o_fmc_nwait && n < 60) begin
            @(negedge clk);
            n++;
         end
         check("nwait_release_wr", bus.o_fmc_nwait, 1);
      end else begin
         seen_low = 1'b0;
         repeat (20) begin
            @(negedge clk);
            if (!bus.o_fmc_nwait) seen_low = 1'b1;
         end
         check("nwait_held_on_addr_mismatch", seen_low, 0);
      end
      bus.i_fmc_nwe = 1'b1;
      repeat (2) @(negedge clk);
      bus.host_d_oe = 1'b0;
      bus.i_fmc_ne1 = 1'b1;
      repeat (4) @(negedge clk);
      check("bus_released_after_wr", bus.fmc_d_oe, 0);
   endtask

   task automatic fmc_read(input logic [25:0] baddr);
      int n;
      logic [31:0] got;
      logic [24:0] a1;
      a1 = baddr[25:1];
      bus.i_fmc_ne1 = 1'b0;
      bus.i_fmc_a   = a1;
      repeat (2) @(negedge clk);
      bus.i_fmc_noe = 1'b0;
      repeat (4) @(negedge clk);
      check("nwait_low_rd_phase1", bus.o_fmc_nwait, 0);
      n = 0;
      while (!bus.o_fmc_nwait && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("nwait_release_rd", bus.o_fmc_nwait, 1);
      check("bus_driven_rd_phase1", bus.fmc_d_oe, 1);
      got[15:0] = bus.io_fmc_d;
      bus.i_fmc_noe = 1'b1;
      repeat (4) @(negedge clk);
      bus.i_fmc_a = a1 + 25'd1;
      repeat (2) @(negedge clk);
      bus.i_fmc_noe = 1'b0;
      repeat (6) @(negedge clk);
      check("nwait_high_rd_phase2", bus.o_fmc_nwait, 1);
      got[31:16] = bus.io_fmc_d;
      bus.i_fmc_noe = 1'b1;
      repeat (2) @(negedge clk);
      bus.i_fmc_ne1 = 1'b1;
      repeat (4) @(negedge clk);
      check("bus_released_after_rd", bus.fmc_d_oe, 0);
      obs_rd.push_back(got);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      exp_err = 0;
      ack_delay = 0;
      ack_rdata = '0;
      late_req = 0;
      rst_n = 1'b0;
      bus.i_fmc_ne1  = 1'b1;
      bus.i_fmc_noe  = 1'b1;
      bus.i_fmc_nwe  = 1'b1;
      bus.i_fmc_a    = '0;
      bus.host_d_out = '0;
      bus.host_d_oe  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_nwait", bus.o_fmc_nwait, 1);
      check("rst_cmd_vld", bus.o_cmd_vld, 0);
      check("rst_rd_wr_n", bus.o_cmd_rd_wr_n, 1);
      check("rst_addr", bus.o_cmd_addr, 0);
      check("rst_wdata", bus.o_cmd_wdata, 0);
      check("rst_err_timeout", bus.o_err_timeout, 0);
      check("rst_bus_released", bus.fmc_d_oe, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Write with ack 5 clocks after vld
      ack_delay = 5;
      push_cmd(1'b0, 26'h1000000, 32'hCAFE_BABE);
      fmc_write(26'h1000000, 32'hCAFE_BABE, 25'h0800001, 1'b1);
      repeat (10) @(negedge clk);

      // Read with ack 8 clocks after vld
      ack_delay = 8;
      ack_rdata = 32'h1234_5678;
      push_cmd(1'b1, 26'h1100000, 32'h0);
      exp_rd.push_back(32'h1234_5678);
      fmc_read(26'h1100000);
      repeat (10) @(negedge clk);

      // Read that is never acked
      ack_delay = 0;
      push_cmd(1'b1, 26'h1200000, 32'h0);
      exp_rd.push_back(32'hDEAD_BEEF);
      exp_err = exp_err + 1;
      fmc_read(26'h1200000);
      repeat (10) @(negedge clk);

      // Back-to-back write then read with ~1 us idle gap
      ack_delay = 3;
      ack_rdata = 32'h89AB_CDEF;
      push_cmd(1'b0, 26'h0000100, 32'h0123_4567);
      fmc_write(26'h0000100, 32'h0123_4567, 25'h0000081, 1'b1);
      repeat (54) @(negedge clk);
      check("bus_z_in_gap", bus.fmc_d_oe, 0);
      repeat (54) @(negedge clk);
      push_cmd(1'b1, 26'h0000200, 32'h0);
      exp_rd.push_back(32'h89AB_CDEF);
      fmc_read(26'h0000200);
      repeat (10) @(negedge clk);

      // Reset while a read waits for its ack
      ack_delay = 0;
      push_cmd(1'b1, 26'h1300000, 32'h0);
      bus.i_fmc_ne1 = 1'b0;
      bus.i_fmc_a   = 25'h0980000;
      repeat (2) @(negedge clk);
      bus.i_fmc_noe = 1'b0;
      repeat (8) @(negedge clk);
      check("nwait_low_before_rst", bus.o_fmc_nwait, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_nwait", bus.o_fmc_nwait, 1);
      check("rst_mid_bus_released", bus.fmc_d_oe, 0);
      check("rst_mid_cmd_vld", bus.o_cmd_vld, 0);
      bus.i_fmc_noe = 1'b1;
      bus.i_fmc_ne1 = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      ack_rdata = 32'hBAD0_BAD0;
      late_req = late_req + 1;
      repeat (20) @(negedge clk);
      check("nwait_after_late_ack", bus.o_fmc_nwait, 1);
      check("bus_z_after_late_ack", bus.fmc_d_oe, 0);

      ack_delay = 4;
      ack_rdata = 32'h5A5A_0F0F;
      push_cmd(1'b1, 26'h1300000, 32'h0);
      exp_rd.push_back(32'h5A5A_0F0F);
      fmc_read(26'h1300000);
      repeat (10) @(negedge clk);

`ifdef FMC_BRIDGE_ADDR_CHECK_EN
      // Phase-2 address off by one more than allowed: no command
      ack_delay = 2;
      fmc_write(26'h0000400, 32'h1111_2222, 25'h0000202, 1'b0);
      repeat (10) @(negedge clk);
      push_cmd(1'b0, 26'h0000400, 32'h3333_4444);
      fmc_write(26'h0000400, 32'h3333_4444, 25'h0000201, 1'b1);
      repeat (10) @(negedge clk);
`endif

      repeat (30) @(negedge clk);
      check("exp_cmd_drained", exp_cmd.size(), 0);
      check("exp_rd_drained", exp_rd.size(), 0);
      check("exp_err_drained", exp_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
